ysyx_24110006_wbu: RTL and testbench

Write-back unit of the multi-cycle core, directly downstream of the load/store unit. It accepts the one-cycle completion pulse from the LSU, selects the write-back value, and owns the general-purpose register file and the architectural PC. It commits the result and the next PC, then pulses `o_valid` to the fetch unit to start the next instruction.

---
 rtl/ysyx_24110006_wbu.sv | 138 +++++++++++++
 tb/tb_ysyx_24110006_wbu.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110006_wbu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24110006_wbu
// Purpose  : Write-back unit. Owns the register file and architectural PC,
//            commits one instruction per LSU pulse and signals the IFU.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_24110006_wbu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NREG     = 32
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_rd_wen,
    input  logic [4:0]  i_rd,
    input  logic [1:0]  i_wb_sel,
    input  logic [31:0] i_alu_res,
    input  logic [31:0] i_lsu_rdata,
    input  logic [31:0] i_csr_rdata,
    input  logic [31:0] i_next_pc,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic [31:0] o_pc,
    output logic        o_valid,
    output logic [4:0]  o_commit_rd,
    output logic [31:0] o_commit_data
);

    localparam int         c_aw   = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0] c_nreg = 6'(NREG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_wen;
    logic [4:0]  r_rd;
    logic [31:0] r_data;
    logic [31:0] r_next_pc;
    logic [31:0] r_pc;
    logic [4:0]  r_commit_rd;
    logic [31:0] r_commit_data;
    logic [31:0] r_regs [NREG];

    logic        w_accept;
    logic        w_do_write;
    logic [31:0] w_wb_data;
    logic        w_rs1_ok;
    logic        w_rs2_ok;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = WRITE;
                end
            end
            WRITE:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // PC+4 is taken from the PC of the instruction being accepted.
    always_comb begin
        w_wb_data = i_alu_res;
        case (i_wb_sel)
            2'b00:   w_wb_data = i_alu_res;
            2'b01:   w_wb_data = i_lsu_rdata;
            2'b10:   w_wb_data = r_pc + 32'd4;
            default: w_wb_data = i_csr_rdata;
        endcase
    end

    assign w_do_write = r_wen && (r_rd != 5'd0) && ({1'b0, r_rd} < c_nreg);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wen         <= 1'b0;
            r_rd          <= '0;
            r_data        <= '0;
            r_next_pc     <= '0;
            r_pc          <= RESET_PC;
            r_commit_rd   <= '0;
            r_commit_data <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_wen     <= i_rd_wen;
                r_rd      <= i_rd;
                r_data    <= w_wb_data;
                r_next_pc <= i_next_pc;
            end
            if (r_state == WRITE) begin
                if (w_do_write) begin
                    r_regs[r_rd[c_aw-1:0]] <= r_data;
                end
                r_pc          <= r_next_pc;
                r_commit_rd   <= w_do_write ? r_rd : 5'd0;
                r_commit_data <= r_data;
            end
        end
    end

    // Reads come straight from the array; a write in flight is not forwarded.
    assign w_rs1_ok   = (i_rs1 != 5'd0) && ({1'b0, i_rs1} < c_nreg);
    assign w_rs2_ok   = (i_rs2 != 5'd0) && ({1'b0, i_rs2} < c_nreg);
    assign o_rs1_data = w_rs1_ok ? r_regs[i_rs1[c_aw-1:0]] : 32'd0;
    assign o_rs2_data = w_rs2_ok ? r_regs[i_rs2[c_aw-1:0]] : 32'd0;

    assign o_pc          = r_pc;
    assign o_valid       = (r_state == DONE);
    assign o_commit_rd   = r_commit_rd;
    assign o_commit_data = r_commit_data;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24110006_wbu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24110006_wbu
// Purpose  : Scoreboard bench for the write-back unit (NREG=32 and NREG=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_24110006_wbu;

    localparam logic [31:0] c_reset_pc = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, wen;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  sel;
    logic [31:0] alu, lsu, csr, npc;

    logic [31:0] rs1_data, rs2_data, pc, commit_data;
    logic        o_valid;
    logic [4:0]  commit_rd;
    logic [31:0] rs1_data16, rs2_data16, pc16, commit_data16;
    logic        o_valid16;
    logic [4:0]  commit_rd16;

    always #5 clk = ~clk;

    ysyx_24110006_wbu #(.RESET_PC(c_reset_pc), .NREG(32)) dut (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_rd_wen(wen), .i_rd(rd),
        .i_wb_sel(sel), .i_alu_res(alu), .i_lsu_rdata(lsu), .i_csr_rdata(csr),
        .i_next_pc(npc), .i_rs1(rs1), .i_rs2(rs2), .o_rs1_data(rs1_data),
        .o_rs2_data(rs2_data), .o_pc(pc), .o_valid(o_valid),
        .o_commit_rd(commit_rd), .o_commit_data(commit_data)
    );

    ysyx_24110006_wbu #(.RESET_PC(c_reset_pc), .NREG(16)) dut16 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_rd_wen(wen), .i_rd(rd),
        .i_wb_sel(sel), .i_alu_res(alu), .i_lsu_rdata(lsu), .i_csr_rdata(csr),
        .i_next_pc(npc), .i_rs1(rs1), .i_rs2(rs2), .o_rs1_data(rs1_data16),
        .o_rs2_data(rs2_data16), .o_pc(pc16), .o_valid(o_valid16),
        .o_commit_rd(commit_rd16), .o_commit_data(commit_data16)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  rd16;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    int          errors = 0;
    int          checks = 0;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = c_reset_pc;
    endtask

    // Predict the commit, then present the instruction for exactly one edge.
    task automatic drive_commit(input logic w, input logic [4:0] r, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] l,
                                input logic [31:0] c, input logic [31:0] n);
        exp_t e;
        case (s)
            2'b00:   e.data = a;
            2'b01:   e.data = l;
            2'b10:   e.data = m_pc + 32'd4;
            default: e.data = c;
        endcase
        e.rd   = (w && r != 5'd0) ? r : 5'd0;
        e.rd16 = (w && r != 5'd0 && r < 5'd16) ? r : 5'd0;
        e.pc   = n;
        sbq.push_back(e);
        @(negedge clk);
        valid = 1'b1; wen = w; rd = r; sel = s; alu = a; lsu = l; csr = c; npc = n;
        @(negedge clk);
        valid = 1'b0;
        wen = 1'($urandom); rd = 5'($urandom); sel = 2'($urandom);
        alu = $urandom; lsu = $urandom; csr = $urandom; npc = $urandom;
    endtask

    task automatic wait_done(output bit got, output int lat);
        got = 1'b0;
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            if (o_valid) begin
                got = 1'b1;
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic retire(output exp_t e);
        if (sbq.size() == 0) begin
            e.rd = '0; e.rd16 = '0; e.data = '0; e.pc = '0;
        end else begin
            e = sbq.pop_front();
            if (e.rd != 5'd0) m_regs[e.rd] = e.data;
            m_pc = e.pc;
        end
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_valid !== 1'b0) begin
                errors++; $display("FAIL reset_valid cycle %0d: got %b want 0", i, o_valid);
            end
            @(negedge clk);
        end
        checks++;
        if (pc !== 32'h8000_0000 || commit_rd !== 5'd0 || commit_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: pc=%h rd=%0d data=%h want 80000000/0/0", pc, commit_rd, commit_data);
        end
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i); #1;
            checks++;
            if (rs1_data !== 32'd0 || rs2_data !== 32'd0 || rs1_data16 !== 32'd0) begin
                errors++;
                $display("FAIL reset_regs idx %0d: rs1=%h rs2=%h rs1_16=%h want 0", i, rs1_data, rs2_data, rs1_data16);
            end
        end
        // Reset and i_valid on the same edge: nothing may be latched.
        @(negedge clk);
        valid = 1'b1; rst = 1'b1; wen = 1'b1; rd = 5'd9; sel = 2'b00; alu = 32'h55;
        @(negedge clk);
        valid = 1'b0; rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_valid) pulses++;
            @(negedge clk);
        end
        rs1 = 5'd9; #1;
        checks++;
        if (pulses != 0 || rs1_data !== 32'd0) begin
            errors++; $display("FAIL reset_with_valid: pulses=%0d x9=%h want 0/0", pulses, rs1_data);
        end
    endtask

    task automatic test_basic();
        bit   got;
        int   lat;
        exp_t e;
        drive_commit(1'b1, 5'd5, 2'b00, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'h8000_0004);
        rs1 = 5'd5; #1;
        checks++;
        if (rs1_data !== 32'd0) begin
            errors++; $display("FAIL basic_no_bypass: x5=%h want 00000000", rs1_data);
        end
        wait_done(got, lat);
        checks++;
        if (!got || lat != 1) begin
            errors++; $display("FAIL basic_latency: got=%0d lat=%0d want 1/1", got, lat);
        end
        retire(e);
        checks++;
        if (commit_rd !== e.rd || commit_data !== e.data || pc !== e.pc) begin
            errors++;
            $display("FAIL basic_commit: rd=%0d data=%h pc=%h want %0d/%h/%h", commit_rd, commit_data, pc, e.rd, e.data, e.pc);
        end
        rs1 = 5'd5; rs2 = 5'd5; #1;
        checks++;
        if (rs1_data !== 32'hDEAD_BEEF || rs2_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL basic_read: rs1=%h rs2=%h want deadbeef", rs1_data, rs2_data);
        end
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL basic_pulse_width: o_valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_sources();
        bit   got;
        int   lat;
        exp_t e;
        for (int i = 1; i <= 4; i++) begin
            drive_commit(1'b1, 5'(i), 2'(i - 1), 32'd1, 32'd2, 32'd4, m_pc + 32'd4);
            wait_done(got, lat);
            retire(e);
            checks++;
            if (!got || commit_rd !== 5'(i) || commit_data !== e.data || pc !== e.pc) begin
                errors++;
                $display("FAIL sources_commit sel=%0d: got=%0d rd=%0d data=%h pc=%h want %0d/%h/%h",
                         i - 1, got, commit_rd, commit_data, pc, i, e.data, e.pc);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            rs1 = 5'(i); #1;
            checks++;
            if (rs1_data !== m_regs[i]) begin
                errors++; $display("FAIL sources_read x%0d: got %h want %h", i, rs1_data, m_regs[i]);
            end
        end
        // x3 is PC+4 of the third commit: 0x8000000C + 4.
        checks++;
        if (m_regs[1] !== 32'd1 || m_regs[2] !== 32'd2 || m_regs[3] !== 32'h8000_0010 || m_regs[4] !== 32'd4) begin
            errors++;
            $display("FAIL sources_values: x1..x4 = %h %h %h %h want 1 2 80000010 4", m_regs[1], m_regs[2], m_regs[3], m_regs[4]);
        end
    endtask

    task automatic test_boundaries();
        bit   got;
        int   lat;
        exp_t e;
        drive_commit(1'b1, 5'd0, 2'b00, 32'h1234, 32'd0, 32'd0, 32'h8000_0020);
        wait_done(got, lat);
        retire(e);
        rs1 = 5'd0; #1;
        checks++;
        if (!got || commit_rd !== 5'd0 || commit_data !== 32'h1234 || rs1_data !== 32'd0) begin
            errors++; $display("FAIL x0_write: rd=%0d data=%h x0=%h want 0/1234/0", commit_rd, commit_data, rs1_data);
        end
        drive_commit(1'b1, 5'd6, 2'b00, 32'h55, 32'd0, 32'd0, 32'hFFFF_FFFC);
        wait_done(got, lat);
        retire(e);
        drive_commit(1'b1, 5'd6, 2'b10, 32'd0, 32'd0, 32'd0, 32'h8000_0100);
        wait_done(got, lat);
        retire(e);
        rs1 = 5'd6; #1;
        checks++;
        if (!got || rs1_data !== 32'd0 || commit_data !== 32'd0 || pc !== 32'h8000_0100) begin
            errors++; $display("FAIL pc4_wrap: x6=%h data=%h pc=%h want 0/0/80000100", rs1_data, commit_data, pc);
        end
        drive_commit(1'b1, 5'd20, 2'b00, 32'hABCD, 32'd0, 32'd0, 32'h8000_0104);
        wait_done(got, lat);
        retire(e);
        rs1 = 5'd20; #1;
        checks++;
        if (!got || rs1_data !== 32'hABCD || commit_rd !== 5'd20) begin
            errors++; $display("FAIL rd20_nreg32: x20=%h rd=%0d want abcd/20", rs1_data, commit_rd);
        end
        checks++;
        if (rs1_data16 !== 32'd0 || commit_rd16 !== e.rd16 || commit_data16 !== 32'hABCD || pc16 !== 32'h8000_0104) begin
            errors++;
            $display("FAIL rd20_nreg16: x20=%h rd=%0d data=%h pc=%h want 0/0/abcd/80000104", rs1_data16, commit_rd16, commit_data16, pc16);
        end
        drive_commit(1'b0, 5'd9, 2'b01, 32'd0, 32'h77, 32'd0, 32'h8000_0200);
        wait_done(got, lat);
        retire(e);
        rs1 = 5'd9; #1;
        checks++;
        if (!got || commit_rd !== 5'd0 || pc !== 32'h8000_0200 || rs1_data !== 32'd0) begin
            errors++; $display("FAIL no_wen: rd=%0d pc=%h x9=%h want 0/80000200/0", commit_rd, pc, rs1_data);
        end
    endtask

    task automatic test_reset_in_write();
        bit   got;
        int   lat;
        int   pulses;
        exp_t e;
        drive_commit(1'b1, 5'd7, 2'b00, 32'hFFFF, 32'd0, 32'd0, 32'h8000_0300);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sbq.pop_front());
        model_reset();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_valid) pulses++;
            @(negedge clk);
        end
        rs1 = 5'd7; rs2 = 5'd5; #1;
        checks++;
        if (pulses != 0 || rs1_data !== 32'd0 || rs2_data !== 32'd0 || pc !== c_reset_pc) begin
            errors++;
            $display("FAIL reset_in_write: pulses=%0d x7=%h x5=%h pc=%h want 0/0/0/80000000", pulses, rs1_data, rs2_data, pc);
        end
        drive_commit(1'b1, 5'd3, 2'b00, 32'h33, 32'd0, 32'd0, 32'h8000_0400);
        wait_done(got, lat);
        retire(e);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rs1 = 5'd3; #1;
        checks++;
        if (!got || o_valid !== 1'b0 || pc !== c_reset_pc || rs1_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_done: got=%0d o_valid=%b pc=%h x3=%h want 1/0/80000000/0", got, o_valid, pc, rs1_data);
        end
    endtask

    task automatic test_back_to_back();
        int   pulses;
        exp_t e;
        drive_commit(1'b1, 5'd8, 2'b00, 32'hAAAA_0008, 32'd0, 32'd0, 32'h8000_0500);
        valid = 1'b1; wen = 1'b1; rd = 5'd9; sel = 2'b00; alu = 32'hBBBB_0009; npc = 32'h8000_0600;
        @(negedge clk);
        valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_valid) pulses++;
            @(negedge clk);
        end
        retire(e);
        rs1 = 5'd8; rs2 = 5'd9; #1;
        checks++;
        if (pulses != 1 || rs1_data !== 32'hAAAA_0008 || rs2_data !== 32'd0 || pc !== 32'h8000_0500) begin
            errors++;
            $display("FAIL back_to_back: pulses=%0d x8=%h x9=%h pc=%h want 1/aaaa0008/0/80000500", pulses, rs1_data, rs2_data, pc);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left want 0", sbq.size());
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; wen = 1'b0; rd = '0; sel = '0;
        alu = '0; lsu = '0; csr = '0; npc = '0; rs1 = '0; rs2 = '0;
        model_reset();
        test_reset();
        test_basic();
        test_sources();
        test_boundaries();
        test_reset_in_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
